// File: rtl/insmem_pkg.sv
// Shared defaults for the instruction memory: widths, NOP word and the
// default program image loaded into storage at power-up.
package insmem_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned DEPTH_DEF  = 256;

  localparam logic [31:0] NOP_WORD = 32'd0;
  localparam logic [31:0] IMG_W0   = 32'd30;
  localparam logic [31:0] IMG_W1   = 32'd30;

  // Default program image: words 0 and 1 hold 30, everything else is NOP.
  function automatic logic [31:0] default_word(input logic [31:0] idx);
    logic [31:0] w;
    w = NOP_WORD;
    if (idx == 32'd0) w = IMG_W0;
    else if (idx == 32'd1) w = IMG_W1;
    return w;
  endfunction

endpackage

// File: rtl/insmem_array.sv
// Instruction storage with an asynchronous read port. By default it is a
// ROM holding the package image; with INSMEM_PROG_EN defined it becomes a
// writable RAM preloaded with the same image.
module insmem_array
  import insmem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
`ifdef INSMEM_PROG_EN
  ,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i
`endif
);

`ifdef INSMEM_PROG_EN
  // Preloaded at configuration time; reset intentionally leaves it alone.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{0: DATA_W'(IMG_W0), 1: DATA_W'(IMG_W1), default: '0};

  // Program write port; reset only blocks writes, it never clears contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
`else
  logic unused_ok;
  assign unused_ok = clk ^ rst_n;

  // Read-only image decoded straight from the package constants.
  assign rdata_o = DATA_W'(default_word(32'(raddr_i)));
`endif

endmodule

// File: rtl/insmem_core.sv
// Instruction memory top: registered fetch with one-cycle latency, hold
// when l=0, NOP for out-of-range addresses, async active-low reset of q.
// Optional program-write port enabled by macro INSMEM_PROG_EN.
module insmem_core
  import insmem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              l,
  input  logic [31:0]       address,
`ifdef INSMEM_PROG_EN
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
`endif
  output logic [DATA_W-1:0] q
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic              in_range;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] q_d;
  logic [DATA_W-1:0] q_q;

  assign in_range = ~|address[31:AW];

  insmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_i (address[AW-1:0]),
    .rdata_o (rdata)
`ifdef INSMEM_PROG_EN
    ,
    .we_i    (we & in_range),
    .waddr_i (address[AW-1:0]),
    .wdata_i (wdata)
`endif
  );

  // Next q: fetch on l, NOP when out of range, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (l) begin
      q_d = in_range ? rdata : DATA_W'(NOP_WORD);
    end
  end

  // Output register; old array word is captured, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: tb/tb_insmem_core.sv
// Self-checking bench for insmem_core with a behavioural memory model.
module tb_insmem_core;

  logic        clk;
  logic        rst_n;
  logic        l;
  logic [31:0] address;
  logic [31:0] q;
`ifdef INSMEM_PROG_EN
  logic        we;
  logic [31:0] wdata;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [256];
  logic [31:0] model_q;

  insmem_core dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .l       (l),
    .address (address),
`ifdef INSMEM_PROG_EN
    .we      (we),
    .wdata   (wdata),
`endif
    .q       (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // Model of one rising edge: fetch sees old contents, then any write lands.
  task automatic model_edge(input logic ld, input logic [31:0] a, input logic wr, input logic [31:0] wd);
    if (rst_n) begin
      if (ld) model_q = (a < 32'd256) ? model_mem[a] : 32'd0;
      if (wr && a < 32'd256) model_mem[a] = wd;
    end
  endtask

  task automatic drive(input logic ld, input logic [31:0] a);
    @(negedge clk);
    l = ld;
    address = a;
`ifdef INSMEM_PROG_EN
    we = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    l = 1'b0;
    address = '0;
`ifdef INSMEM_PROG_EN
    we = 1'b0;
    wdata = '0;
`endif
    model_q = 32'd0;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'd0;
    model_mem[0] = 32'd30;
    model_mem[1] = 32'd30;
    #12;
    checks++;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL reset_init q=%h expected=%h", q, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    drive(1'b1, 32'd0);
    edge_sample();
    model_edge(1'b1, 32'd0, 1'b0, 32'd0);
    checks++;
    if (q !== 32'd30 || q !== model_q) begin
      errors++;
      $display("FAIL fetch_w0 q=%h expected=%h", q, 32'd30);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      checks++;
      if (q !== 32'd30) begin
        errors++;
        $display("FAIL hold_edge%0d q=%h expected=%h", i, q, 32'd30);
      end
    end
    @(negedge clk);
    address = 32'd2;
    #1;
    checks++;
    if (q !== 32'd30) begin
      errors++;
      $display("FAIL hold_comb q=%h expected=%h", q, 32'd30);
    end
    edge_sample();
    checks++;
    if (q !== 32'd30) begin
      errors++;
      $display("FAIL hold_addr2 q=%h expected=%h", q, 32'd30);
    end
  endtask

  task automatic test_range();
    drive(1'b1, 32'd1);
    edge_sample();
    checks++;
    if (q !== 32'd30) begin
      errors++;
      $display("FAIL range_pre q=%h expected=%h", q, 32'd30);
    end
    drive(1'b1, 32'h0000_0100);
    edge_sample();
    checks++;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL range_256 q=%h expected=%h", q, 32'd0);
    end
    drive(1'b1, 32'd0);
    edge_sample();
    drive(1'b1, 32'h8000_0001);
    edge_sample();
    checks++;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL range_high q=%h expected=%h", q, 32'd0);
    end
    drive(1'b1, 32'd255);
    edge_sample();
    checks++;
    if (q !== model_mem[255]) begin
      errors++;
      $display("FAIL range_last q=%h expected=%h", q, model_mem[255]);
    end
    model_q = model_mem[255];
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'd0);
    edge_sample();
    model_q = model_mem[0];
    checks++;
    if (q !== model_mem[0]) begin
      errors++;
      $display("FAIL arst_pre q=%h expected=%h", q, model_mem[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL arst_immediate q=%h expected=%h", q, 32'd0);
    end
    model_q = 32'd0;
    @(negedge clk);
    l = 1'b1;
    address = 32'd1;
`ifdef INSMEM_PROG_EN
    we = 1'b1;
    wdata = 32'h1234_5678;
`endif
    edge_sample();
    checks++;
    if (q !== 32'd0) begin
      errors++;
      $display("FAIL arst_fetch_ignored q=%h expected=%h", q, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
`ifdef INSMEM_PROG_EN
    we = 1'b0;
`endif
    edge_sample();
    model_q = model_mem[1];
    checks++;
    if (q !== model_mem[1]) begin
      errors++;
      $display("FAIL arst_first_fetch q=%h expected=%h", q, model_mem[1]);
    end
  endtask

`ifdef INSMEM_PROG_EN
  task automatic test_program();
    @(negedge clk);
    l = 1'b0; we = 1'b1; address = 32'd5; wdata = 32'hDEAD_BEEF;
    edge_sample();
    model_edge(1'b0, 32'd5, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    we = 1'b1; address = 32'h0000_0105; wdata = 32'h0BAD_0BAD;
    edge_sample();
    model_edge(1'b0, 32'h105, 1'b1, 32'h0BAD_0BAD);
    drive(1'b1, 32'd5);
    edge_sample();
    model_edge(1'b1, 32'd5, 1'b0, 32'd0);
    checks++;
    if (q !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL program_w5 q=%h expected=%h", q, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    l = 1'b1; we = 1'b1; address = 32'd0; wdata = 32'd7;
    edge_sample();
    model_edge(1'b1, 32'd0, 1'b1, 32'd7);
    checks++;
    if (q !== 32'd30) begin
      errors++;
      $display("FAIL collision_old q=%h expected=%h", q, 32'd30);
    end
    drive(1'b1, 32'd0);
    edge_sample();
    model_edge(1'b1, 32'd0, 1'b0, 32'd0);
    checks++;
    if (q !== 32'd7) begin
      errors++;
      $display("FAIL collision_new q=%h expected=%h", q, 32'd7);
    end
  endtask
`endif

  task automatic test_random();
    logic        ld;
    logic [31:0] a;
    logic        wr;
    logic [31:0] wd;
    for (int i = 0; i < 300; i++) begin
      ld = ($urandom_range(0, 3) != 0);
      a  = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 255));
      wr = 1'b0;
      wd = $urandom();
`ifdef INSMEM_PROG_EN
      wr = ($urandom_range(0, 2) == 0);
`endif
      @(negedge clk);
      l = ld;
      address = a;
`ifdef INSMEM_PROG_EN
      we = wr;
      wdata = wd;
`endif
      edge_sample();
      model_edge(ld, a, wr, wd);
      checks++;
      if (q !== model_q) begin
        errors++;
        $display("FAIL random_%0d l=%b addr=%h q=%h expected=%h", i, ld, a, q, model_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_hold();
    test_range();
    test_async_reset();
`ifdef INSMEM_PROG_EN
    test_program();
    test_collision();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/insmem_core.md
INSMEM_CORE -- requirements
Module: insMem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 256, number of instruction words (power of two).
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 Port l, input, 1, load/read enable; 1 = fetch word at address into q, 0 = hold q.
REQ-006 Port address, input, 32, word index (not byte address) of the instruction to fetch.
REQ-007 Port q, output, DATA_W, registered instruction word.
REQ-008 With INSMEM_PROG_EN only: port we, input, 1, program-write strobe; port wdata, input, DATA_W, program word; writes use address.

Function
REQ-009 Storage SHALL be DEPTH words of DATA_W bits, word-indexed by address[log2(DEPTH)-1:0].
REQ-010 At power-up, storage SHALL hold the default program image from the shared package: word 0 = 32'd30, word 1 = 32'd30, all other words = 32'd0.
REQ-011 On a rising clk edge with l=1, q SHALL take the stored word at address; read latency is exactly one cycle.
REQ-012 On a rising clk edge with l=0, q SHALL hold its previous value regardless of address changes.
REQ-013 An address with any bit at or above log2(DEPTH) set is out of range; a fetch (l=1) from it SHALL load q with 32'd0 (NOP).
REQ-014 address and l SHALL be sampled only at the clock edge; q SHALL NOT change combinationally with address.
REQ-015 q SHALL never be X after reset, including when reading uninitialised or out-of-range locations.

Reset
REQ-016 rst_n low SHALL immediately, without waiting for clk, force q to 32'd0.
REQ-017 While rst_n is low, fetches and writes SHALL be ignored.
REQ-018 Reset SHALL NOT alter storage contents.
REQ-019 The first fetch SHALL occur on the first rising clk edge after rst_n deasserts with l=1.

Configuration
REQ-020 Macro INSMEM_PROG_EN: when defined, we/wdata exist; a rising edge with we=1 and in-range address SHALL write wdata to storage; out-of-range writes SHALL be dropped.
REQ-021 With INSMEM_PROG_EN, simultaneous we=1 and l=1 to the same address SHALL return the old word in q (read-before-write); the new word is visible on the next fetch.
REQ-022 Without INSMEM_PROG_EN, we/wdata SHALL be absent and storage SHALL be read-only (ROM).

Structure
REQ-023 A shared package insmem_pkg SHALL hold DATA_W default, DEPTH default, NOP word (32'd0) and the default program image constants.
REQ-024 One sub-module insmem_array (storage plus optional write port) is natural; the top holds the q register, enable and range logic.

Verification
REQ-025 Reset: rst_n=0 mid-cycle with q=30 -> q=0 immediately, before the next clk edge.
REQ-026 Fetch: after reset, l=1, address=0, one clk edge -> q=32'd30.
REQ-027 Hold: q=30, then l=0, address=1, three edges -> q stays 32'd30; address=2 with l=0 -> q unchanged.
REQ-028 Range: l=1, address=32'h0000_0100 (DEPTH=256) -> q=32'd0 after one edge.
REQ-029 Program (INSMEM_PROG_EN): we=1, address=5, wdata=32'hDEAD_BEEF, then l=1, address=5 -> q=32'hDEAD_BEEF.
REQ-030 Same-address collision (INSMEM_PROG_EN): word 0=30, we=1, l=1, address=0, wdata=7 -> q=30; next fetch -> q=7.
